// File: rtl/shifter_pkg.sv
// Shared definitions for the serial shifter stages: state encoding and
// default word geometry.
package shifter_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_CWIDTH = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_in_out_reg.sv
// Output holding register for shift_in.
// It accepts a completed word when empty or being drained the same cycle.
// Otherwise it drops the word and latches a sticky overrun flag.
module out_reg
  import shifter_pkg::*;
#(
  parameter int unsigned width = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [width-1:0] i_word,
  input  logic             i_ready,
  output logic [width-1:0] o_dout,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [width-1:0] r_dout;
  logic             r_valid;
  logic             r_overrun;

  // Load, drain or drop; overrun is cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (i_load && (!r_valid || i_ready)) begin
        r_dout  <= i_word;
        r_valid <= 1'b1;
      end else if (i_load) begin
        r_overrun <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_dout    = r_dout;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/shift_in.sv
// Serial-to-parallel converter.
// Captures sin LSB first, one bit per enabled clock after a start request.
// Completed words are handed to a valid/ready output register.
module shift_in
  import shifter_pkg::*;
#(
  parameter int unsigned width  = DEF_WIDTH,
  parameter int unsigned cwidth = DEF_CWIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             enable,
  input  logic             sin,
  input  logic             ready,
  output logic [width-1:0] dout,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  localparam logic [cwidth-1:0] LAST_IDX = cwidth'(width - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [cwidth-1:0] r_index;
  logic [cwidth-1:0] w_index_nxt;
  logic [width-1:0]  r_sreg;
  logic [width-1:0]  w_sreg_nxt;
  logic              w_complete;
  logic [width-1:0]  w_word;

  // State, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_index <= '0;
      r_sreg  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      r_sreg  <= w_sreg_nxt;
    end
  end

  // Next-state logic; start has priority over enable, so a restart ignores sin.
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_sreg_nxt  = r_sreg;
    w_complete  = 1'b0;
    // The last bit goes straight into the word, bypassing the shift register.
    w_word      = {sin, r_sreg[width-2:0]};
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SHIFT;
          w_index_nxt = '0;
          w_sreg_nxt  = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          w_index_nxt = '0;
          w_sreg_nxt  = '0;
        end else if (enable) begin
          w_sreg_nxt[r_index] = sin;
          if (r_index == LAST_IDX) begin
            w_complete  = 1'b1;
            w_state_nxt = IDLE;
            w_index_nxt = '0;
          end else begin
            w_index_nxt = r_index + cwidth'(1);
          end
        end
      end
    endcase
  end

  assign busy = (r_state == SHIFT);

  out_reg #(
    .width (width)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_complete),
    .i_word    (w_word),
    .i_ready   (ready),
    .o_dout    (dout),
    .o_valid   (valid),
    .o_overrun (overrun)
  );

endmodule

// File: tb/tb_shift_in.sv
module tb_shift_in;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         start  = 1'b0;
  logic         enable = 1'b0;
  logic         sin    = 1'b0;
  logic         ready  = 1'b0;
  logic [W-1:0] dout;
  logic         valid;
  logic         busy;
  logic         overrun;

  int n_vec  = 0;
  int n_miss = 0;
  logic [W-1:0] sb_q[$];

  always #5 clk = ~clk;

  shift_in #(
    .width  (W),
    .cwidth (CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .enable  (enable),
    .sin     (sin),
    .ready   (ready),
    .dout    (dout),
    .valid   (valid),
    .busy    (busy),
    .overrun (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Valid must be up and dout must match the oldest expected word.
  task automatic check_out(input string tag);
    logic [W-1:0] e;
    check({tag, ".valid"}, {31'd0, valid}, 32'd1);
    if (sb_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $error("FAIL %s.dout: observed %0h expected <no word queued>", tag, dout);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".dout"}, {24'd0, dout}, {24'd0, e});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic en);
    sin    = b;
    enable = en;
    tick();
    enable = 1'b0;
  endtask

  // Start cycle drives enable/sin high to show they are ignored.
  task automatic do_start();
    start  = 1'b1;
    enable = 1'b1;
    sin    = 1'b1;
    tick();
    start  = 1'b0;
    enable = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy_last, input logic chk_pre, input string tag);
    do_start();
    for (int i = 0; i < int'(W); i++) begin
      if (i == int'(W) - 1) begin
        if (chk_pre) check({tag, ".pre_valid"}, {31'd0, valid}, 32'd0);
        check({tag, ".pre_busy"}, {31'd0, busy}, 32'd1);
        ready = rdy_last;
      end
      send_bit(w[i], 1'b1);
      ready = 1'b0;
    end
  endtask

  task automatic consume(input string tag);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check({tag, ".drained"}, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] w;

    // Reset state
    #12;
    check("rst.dout", {24'd0, dout}, 32'd0);
    check("rst.valid", {31'd0, valid}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Ready with nothing valid has no effect
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("idle_ready.valid", {31'd0, valid}, 32'd0);

    // Basic word 9A
    sb_q.push_back(8'h9A);
    send_word(8'h9A, 1'b0, 1'b1, "w9A");
    check_out("w9A");
    check("w9A.busy", {31'd0, busy}, 32'd0);
    consume("w9A");

    // Same word, enable low on alternate cycles with complemented sin
    w = 8'h9A;
    do_start();
    for (int i = 0; i < int'(W); i++) begin
      if (i > 0) send_bit(~w[i], 1'b0);
      if (i == 4) begin
        check("alt.mid_busy", {31'd0, busy}, 32'd1);
        check("alt.mid_valid", {31'd0, valid}, 32'd0);
      end
      if (i == int'(W) - 1) sb_q.push_back(8'h9A);
      send_bit(w[i], 1'b1);
    end
    check_out("alt");
    check("alt.busy", {31'd0, busy}, 32'd0);
    consume("alt");

    // Held word, second completes unaccepted -> dropped, overrun
    sb_q.push_back(8'h9A);
    send_word(8'h9A, 1'b0, 1'b1, "hold1");
    send_word(8'h3C, 1'b0, 1'b0, "hold2");
    check_out("hold2");
    check("hold2.overrun", {31'd0, overrun}, 32'd1);
    consume("hold2");
    check("hold2.sticky", {31'd0, overrun}, 32'd1);

    // Reset clears overrun
    rst_n = 1'b0;
    #1;
    check("rst2.overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Ready on the completing edge of the second word -> reload
    send_word(8'h9A, 1'b0, 1'b1, "rl1");
    sb_q.push_back(8'h3C);
    send_word(8'h3C, 1'b1, 1'b0, "rl2");
    check_out("rl2");
    check("rl2.overrun", {31'd0, overrun}, 32'd0);
    consume("rl2");

    // Abort after 4 bits, then full FF word
    do_start();
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b1);
    sb_q.push_back(8'hFF);
    send_word(8'hFF, 1'b0, 1'b1, "abort");
    check_out("abort");
    check("abort.overrun", {31'd0, overrun}, 32'd0);

    // FF left valid; reset mid-word forces all outputs low at once
    do_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst.dout", {24'd0, dout}, 32'd0);
    check("midrst.valid", {31'd0, valid}, 32'd0);
    check("midrst.busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1);
    check("post_rst.busy", {31'd0, busy}, 32'd0);
    check("post_rst.valid", {31'd0, valid}, 32'd0);
    check("post_rst.dout", {24'd0, dout}, 32'd0);

    // Normal operation resumes on a new start
    sb_q.push_back(8'h5A);
    send_word(8'h5A, 1'b0, 1'b1, "w5A");
    check_out("w5A");
    consume("w5A");

    check("sb.empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
